ultrasonic_ranger: RTL and testbench

Drives an HC-SR04-style ultrasonic sensor and converts each echo pulse into an unsigned distance in centimetres. It sits directly upstream of the PID controller. `distance` feeds the controller's `feedback` input, and `valid` is used as the controller's `clk_en`, so the loop updates exactly once per fresh measurement. Measurements repeat at a fixed period while enabled, and a missing or overlong echo produces a flagged saturated result.

---
 rtl/ultrasonic_ranger.sv | 145 ++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ultrasonic ranger: periodic trigger, echo pulse timed in clock cycles,
// result converted to whole centimetres with a flagged saturated timeout result.
module ultrasonic_ranger #(
  parameter int CLKS_PER_US = 100,
  parameter int TRIG_US     = 10,
  parameter int US_PER_CM   = 58,
  parameter int TIMEOUT_US  = 30000,
  parameter int PERIOD_US   = 60000,
  parameter int PV_WIDTH    = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                echo,
  output logic                trig,
  output logic [PV_WIDTH-1:0] distance,
  output logic                valid,
  output logic                timeout
);

  localparam int unsigned T_TRIG = TRIG_US * CLKS_PER_US;
  localparam int unsigned T_CM   = US_PER_CM * CLKS_PER_US;
  localparam int unsigned T_TO   = TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned T_PER  = PERIOD_US * CLKS_PER_US;
  localparam int unsigned T_TMAX = (T_TO > T_TRIG) ? T_TO : T_TRIG;

  localparam int TW = $clog2(T_TMAX + 1);
  localparam int PW = $clog2(T_PER + 1);
  localparam int SW = (T_CM > 1) ? $clog2(T_CM) : 1;

  // The cycle that detects the rise already carries echo, so it is counted on entry.
  localparam logic [SW-1:0]       SUB_INIT = (T_CM == 1) ? '0 : SW'(1);
  localparam logic [PV_WIDTH-1:0] CM_INIT  = (T_CM == 1) ? PV_WIDTH'(1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t              state;
  logic                sync1;
  logic                echo_s;
  logic [TW-1:0]       timer;
  logic [PW-1:0]       period_cnt;
  logic [SW-1:0]       sub_cnt;
  logic [PV_WIDTH-1:0] cm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      echo_s     <= 1'b0;
      timer      <= '0;
      period_cnt <= '0;
      sub_cnt    <= '0;
      cm_cnt     <= '0;
      trig       <= 1'b0;
      distance   <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      sync1  <= echo;
      echo_s <= sync1;
      valid  <= 1'b0;
      trig   <= en && (state == TRIG);

      if (state != IDLE)
        period_cnt <= period_cnt + 1'b1;
      if (state == TRIG || state == WAIT_RISE || state == MEASURE)
        timer <= timer + 1'b1;

      if (!en && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              state      <= TRIG;
              timer      <= '0;
              period_cnt <= '0;
            end
          end

          TRIG: begin
            if (timer == TW'(T_TRIG - 1)) begin
              state <= WAIT_RISE;
              timer <= '0;
            end
          end

          WAIT_RISE: begin
            if (echo_s) begin
              state   <= MEASURE;
              timer   <= '0;
              sub_cnt <= SUB_INIT;
              cm_cnt  <= CM_INIT;
            end else if (timer == TW'(T_TO)) begin
              state    <= HOLDOFF;
              timer    <= '0;
              distance <= '1;
              timeout  <= 1'b1;
              valid    <= 1'b1;
            end
          end

          MEASURE: begin
            if (!echo_s) begin
              state    <= HOLDOFF;
              timer    <= '0;
              distance <= cm_cnt;
              timeout  <= 1'b0;
              valid    <= 1'b1;
            end else if (timer == TW'(T_TO)) begin
              state    <= HOLDOFF;
              timer    <= '0;
              distance <= '1;
              timeout  <= 1'b1;
              valid    <= 1'b1;
            end else if (sub_cnt == SW'(T_CM - 1)) begin
              sub_cnt <= '0;
              if (cm_cnt != '1)
                cm_cnt <= cm_cnt + 1'b1;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end

          HOLDOFF: begin
            if (period_cnt == PW'(T_PER - 1)) begin
              state      <= TRIG;
              timer      <= '0;
              period_cnt <= '0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: directed and random echo pulses checked against a
// timing/distance model; a second instance with PV_WIDTH=4 checks cm saturation.
module tb_ultrasonic_ranger;

  localparam int CLKS_PER_US = 1;
  localparam int TRIG_US     = 10;
  localparam int US_PER_CM   = 4;
  localparam int TIMEOUT_US  = 200;
  localparam int PERIOD_US   = 500;

  localparam int T_TRIG = TRIG_US * CLKS_PER_US;
  localparam int T_CM   = US_PER_CM * CLKS_PER_US;
  localparam int T_TO   = TIMEOUT_US * CLKS_PER_US;
  localparam int T_PER  = PERIOD_US * CLKS_PER_US;
  localparam int MAX_A  = 511;
  localparam int MAX_B  = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       echo = 1'b0;
  logic       trig, trig_b;
  logic [8:0] dist_a;
  logic [3:0] dist_b;
  logic       valid_a, valid_b;
  logic       to_a, to_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int prev_rise = -1;
  int pending_rise = -1;

  ultrasonic_ranger #(
    .CLKS_PER_US(CLKS_PER_US), .TRIG_US(TRIG_US), .US_PER_CM(US_PER_CM),
    .TIMEOUT_US(TIMEOUT_US), .PERIOD_US(PERIOD_US), .PV_WIDTH(9)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .echo(echo),
    .trig(trig), .distance(dist_a), .valid(valid_a), .timeout(to_a)
  );

  ultrasonic_ranger #(
    .CLKS_PER_US(CLKS_PER_US), .TRIG_US(TRIG_US), .US_PER_CM(US_PER_CM),
    .TIMEOUT_US(TIMEOUT_US), .PERIOD_US(PERIOD_US), .PV_WIDTH(4)
  ) dut_sat (
    .clk(clk), .reset(reset), .en(en), .echo(echo),
    .trig(trig_b), .distance(dist_b), .valid(valid_b), .timeout(to_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected result for an echo driven w cycles long, d cycles after trig is seen low.
  // rel is the cycle offset from the trig fall to the valid strobe.
  function automatic void model(input int d, input int w, output int rel,
                                output bit to, output int cm);
    cm = 0;
    if (w == 0 || d > T_TO - 3) begin
      to  = 1'b1;
      rel = T_TO;
    end else if (w <= T_TO + 1) begin
      to  = 1'b0;
      rel = d + w + 3;
      cm  = w / T_CM;
    end else begin
      to  = 1'b1;
      rel = d + T_TO + 4;
    end
  endfunction

  task automatic wait_trig_rise(output int rt, output bit ok);
    logic prev;
    prev = trig;
    ok = 1'b0;
    rt = -1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (trig === 1'b1 && prev === 1'b0) begin
        rt = cyc;
        ok = 1'b1;
        break;
      end
      prev = trig;
    end
    if (!ok) check("trig_rise_wait", 0, 1);
  endtask

  task automatic wait_trig_fall(output int f);
    int k;
    k = 0;
    while (trig === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    f = cyc;
  endtask

  task automatic run_meas(input int d, input int w, input string tag);
    int rt, f, rel, cm, vcyc, nvalid, ga, gb, gta, gtb, gvb, gtrb;
    bit to, ok;
    if (pending_rise >= 0) begin
      rt = pending_rise;
      pending_rise = -1;
    end else begin
      wait_trig_rise(rt, ok);
      if (!ok) return;
    end
    if (prev_rise >= 0) check({tag, "_period"}, rt - prev_rise, T_PER);
    prev_rise = rt;
    gtrb = int'(trig_b);
    wait_trig_fall(f);
    check({tag, "_trig_w"}, f - rt, T_TRIG);
    model(d, w, rel, to, cm);
    vcyc = -1; nvalid = 0; ga = 0; gb = 0; gta = 0; gtb = 0; gvb = 0;
    for (int k = 0; k < 600; k++) begin
      echo = (w > 0 && cyc >= f + d && cyc < f + d + w);
      @(negedge clk);
      if (valid_a === 1'b1) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = cyc; ga = int'(dist_a); gb = int'(dist_b);
          gta = int'(to_a); gtb = int'(to_b); gvb = int'(valid_b);
        end
      end
      if (vcyc >= 0 && cyc > vcyc && cyc >= f + d + w) break;
    end
    echo = 1'b0;
    check({tag, "_trig_b"}, gtrb, 1);
    check({tag, "_latency"}, vcyc - f, rel);
    check({tag, "_valid_cnt"}, nvalid, 1);
    check({tag, "_valid_b"}, gvb, 1);
    check({tag, "_dist"}, ga, to ? MAX_A : (cm > MAX_A ? MAX_A : cm));
    check({tag, "_timeout"}, gta, int'(to));
    check({tag, "_dist_sat"}, gb, to ? MAX_B : (cm > MAX_B ? MAX_B : cm));
    check({tag, "_timeout_sat"}, gtb, int'(to));
  endtask

  initial begin
    int rt, f, c, d, w, nv, ntr, hold_d, hold_t;
    bit ok;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_trig", int'(trig), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_dist", int'(dist_a), 0);
    check("rst_timeout", int'(to_a), 0);

    en = 1'b1;
    c = cyc;
    wait_trig_rise(rt, ok);
    check("start_latency", rt - c, 2);
    pending_rise = rt;

    run_meas(5, 100, "nom100");
    run_meas(5, 103, "nom103");
    run_meas(0, 0, "no_echo");
    run_meas(5, 40, "nom40");
    run_meas(5, 300, "stuck");
    run_meas(2, 80, "sat80");
    run_meas(0, 1, "w1");
    run_meas(7, 4, "w4");
    run_meas(3, T_TO + 1, "edge_good");
    run_meas(3, T_TO + 2, "edge_to");

    for (int i = 0; i < 14; i++) begin
      d = $urandom_range(0, 150);
      w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 320);
      run_meas(d, w, $sformatf("rnd%0d", i));
    end

    // Drop enable while the trigger is high.
    wait_trig_rise(rt, ok);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("dis_trig_drop", int'(trig), 0);
    repeat (5) @(negedge clk);

    // Re-enable, then drop enable mid-measurement.
    en = 1'b1;
    c = cyc;
    wait_trig_rise(rt, ok);
    check("reen_latency", rt - c, 2);
    wait_trig_fall(f);
    hold_d = int'(dist_a);
    hold_t = int'(to_a);
    nv = 0; ntr = 0;
    for (int k = 0; k < 330; k++) begin
      echo = (cyc >= f + 2 && cyc < f + 60);
      if (cyc == f + 30) en = 1'b0;
      @(negedge clk);
      if (valid_a === 1'b1) nv++;
      if (trig === 1'b1) ntr++;
    end
    echo = 1'b0;
    check("dis_meas_valid", nv, 0);
    check("dis_meas_trig", ntr, 0);
    check("dis_meas_dist", int'(dist_a), hold_d);
    check("dis_meas_timeout", int'(to_a), hold_t);

    en = 1'b1;
    c = cyc;
    wait_trig_rise(rt, ok);
    check("reen2_latency", rt - c, 2);
    prev_rise = -1;
    pending_rise = rt;
    run_meas(3, 48, "after_reen");

    // Reset in the middle of a measurement.
    wait_trig_rise(rt, ok);
    wait_trig_fall(f);
    for (int k = 0; k < 30; k++) begin
      echo = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_trig", int'(trig), 0);
    check("rst_mid_valid", int'(valid_a), 0);
    check("rst_mid_dist", int'(dist_a), 0);
    check("rst_mid_timeout", int'(to_a), 0);
    echo = 1'b0;
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
